rock_sequencer: RTL and testbench

- FSM controller that steps the F/A counter block (frequency F, amplitude A; flags F0, AF0) through a rocking session.
- Runs a timed observation window, samples the cry sensor, then issues exactly one single-cycle step pulse: Fhoog (raise F), Flaag (lower F) or Alaag (lower A).
- Ends the session when F and A are both zero.
- Sits between the user start/stop controls, the cry sensor and the F/A counter block.

---
 rtl/rock_sequencer_if.sv | 29 ++
 rtl/rock_sequencer.sv | 156 +++++++++++++++
 tb/tb_rock_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rock_sequencer_if.sv
// rock_sequencer_if
// Groups the sequencer's control, sensor and step signals into one bundle.
//   master : the sequencer's view. It receives start, stop, cry, F0 and AF0,
//            and drives Fhoog, Flaag, Alaag, busy, done and f_level.
//   slave  : the environment's view. This covers the user controls, the cry
//            sensor and the F/A counter block.
interface rock_sequencer_if;
    logic       start;    // level: begin a session while idle
    logic       stop;     // level: abort to idle (wins over start)
    logic       cry;      // asynchronous cry sensor
    logic       F0;       // F == 0 from the F/A counter block
    logic       AF0;      // F == 0 and A == 0 from the F/A counter block
    logic       Fhoog;    // one-cycle pulse: raise F
    logic       Flaag;    // one-cycle pulse: lower F
    logic       Alaag;    // one-cycle pulse: lower A
    logic       busy;     // session in progress
    logic       done;     // session finished
    logic [3:0] f_level;  // shadow copy of F

    modport master (
        input  start, stop, cry, F0, AF0,
        output Fhoog, Flaag, Alaag, busy, done, f_level
    );

    modport slave (
        output start, stop, cry, F0, AF0,
        input  Fhoog, Flaag, Alaag, busy, done, f_level
    );
endinterface

// File: rtl/rock_sequencer.sv
// rock_sequencer
// Steps an F/A counter block through a rocking session. Each step works as
// follows:
//   - Watch the synchronised cry sensor for SETTLE_CYCLES cycles.
//   - Decide what to do next.
//   - Issue exactly one single-cycle step pulse (Fhoog, Flaag or Alaag).
//   - Hold one idle gap cycle.
// The session ends once the counter block reports F == 0 and A == 0.
//
// Ports
//   clk   : system clock. All logic is on the rising edge.
//   reset : asynchronous, active-low reset.
//   bus   : rock_sequencer_if.master. It carries the start/stop/cry/F0/AF0
//           inputs and the Fhoog/Flaag/Alaag/busy/done/f_level outputs.
//
// Optional feature (macro ROCK_CRY_RESTART_EN)
//   Defined   : a synchronised cry while in DONE resumes the session.
//   Undefined : DONE is left only through start (rising edge) or stop.
module rock_sequencer #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int F_INIT        = 5,
    parameter int F_MAX         = 15
) (
    input  logic             clk,
    input  logic             reset,
    rock_sequencer_if.master bus
);
    localparam int         CW       = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] F_MAX_L  = 4'(F_MAX);
    localparam logic [3:0] F_INIT_L = 4'(F_INIT);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_DECIDE, S_PULSE, S_GAP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cry_seen_q, cry_seen_d;
    logic [3:0]    f_level_q, f_level_d;
    logic          fhoog_q, fhoog_d;
    logic          flaag_q, flaag_d;
    logic          alaag_q, alaag_d;
    logic          cry_meta_q, cry_meta_d;
    logic          cry_sync_q, cry_sync_d;
    logic          start_prev_q, start_prev_d;
    logic          enter_settle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cry_seen_q   <= 1'b0;
            f_level_q    <= F_INIT_L;
            fhoog_q      <= 1'b0;
            flaag_q      <= 1'b0;
            alaag_q      <= 1'b0;
            cry_meta_q   <= 1'b0;
            cry_sync_q   <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cry_seen_q   <= cry_seen_d;
            f_level_q    <= f_level_d;
            fhoog_q      <= fhoog_d;
            flaag_q      <= flaag_d;
            alaag_q      <= alaag_d;
            cry_meta_q   <= cry_meta_d;
            cry_sync_q   <= cry_sync_d;
            start_prev_q <= start_prev_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cry_seen_d   = cry_seen_q;
        f_level_d    = f_level_q;
        fhoog_d      = 1'b0;
        flaag_d      = 1'b0;
        alaag_d      = 1'b0;
        cry_meta_d   = bus.cry;
        cry_sync_d   = cry_meta_q;
        start_prev_d = bus.start;
        enter_settle = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) enter_settle = 1'b1;
            end
            S_SETTLE: begin
                // This captures a cry on the last window cycle as well,
                // because cry_seen is registered on the edge into DECIDE.
                cry_seen_d = cry_seen_q | cry_sync_q;
                if (cnt_q == '0) state_d = S_DECIDE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DECIDE: begin
                // Step outputs and f_level update on the edge into PULSE.
                // As a result, f_level already shows the new value while the
                // pulse is high.
                if (cry_seen_q) begin
                    if (f_level_q < F_MAX_L) begin
                        state_d   = S_PULSE;
                        fhoog_d   = 1'b1;
                        f_level_d = f_level_q + 4'd1;
                    end else begin
                        enter_settle = 1'b1;
                    end
                end else if (bus.AF0) begin
                    state_d = S_DONE;
                end else if (!bus.F0) begin
                    state_d = S_PULSE;
                    flaag_d = 1'b1;
                    if (f_level_q != 4'd0) f_level_d = f_level_q - 4'd1;
                end else begin
                    state_d = S_PULSE;
                    alaag_d = 1'b1;
                end
            end
            S_PULSE: state_d = S_GAP;
            S_GAP:   enter_settle = 1'b1;
            S_DONE: begin
                if (bus.start && !start_prev_q) enter_settle = 1'b1;
`ifdef ROCK_CRY_RESTART_EN
                if (cry_sync_q) enter_settle = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_settle) begin
            state_d    = S_SETTLE;
            cnt_d      = CNT_LOAD;
            cry_seen_d = 1'b0;
        end

        // stop overrides everything. Any pulse that was about to start is
        // dropped, and the shadow level keeps its value.
        if (bus.stop) begin
            state_d   = S_IDLE;
            fhoog_d   = 1'b0;
            flaag_d   = 1'b0;
            alaag_d   = 1'b0;
            f_level_d = f_level_q;
        end
    end

    assign bus.Fhoog   = fhoog_q;
    assign bus.Flaag   = flaag_q;
    assign bus.Alaag   = alaag_q;
    assign bus.busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.f_level = f_level_q;
endmodule

// File: tb/tb_rock_sequencer.sv
// tb_rock_sequencer
// Scoreboard bench for rock_sequencer. The stimulus code queues the expected
// step pulses and done events. A separate monitor compares each event as the
// DUT presents it. The F/A counter block is modelled behaviourally so that F0
// and AF0 follow the pulses.
module tb_rock_sequencer;
    localparam int K_HOOG = 1, K_LAAG = 2, K_ALAAG = 3, K_DONE = 4;

    typedef struct {
        int kind;
        int lvl;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ev_t  q[$];
    int   f_cnt, a_cnt;
    logic done_prev = 1'b0;
    int   mon_kind;
    int   mon_hot;
    ev_t  mon_e;

    rock_sequencer_if ifc();

    rock_sequencer #(.SETTLE_CYCLES(4), .F_INIT(5), .F_MAX(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // F/A counter block model.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_cnt <= 5;
            a_cnt <= 5;
        end else begin
            if (ifc.Fhoog && f_cnt < 15) f_cnt <= f_cnt + 1;
            if (ifc.Flaag && f_cnt > 0)  f_cnt <= f_cnt - 1;
            if (ifc.Alaag && a_cnt > 0)  a_cnt <= a_cnt - 1;
        end
    end
    assign ifc.F0  = (f_cnt == 0);
    assign ifc.AF0 = (f_cnt == 0) && (a_cnt == 0);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int lvl);
        ev_t e;
        e.kind = kind;
        e.lvl  = lvl;
        q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1 ifc.stop = 1'b1;
        @(posedge clk); #1 ifc.stop = 1'b0;
    endtask

    // Monitor: compares each pulse or done-rise against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            mon_hot  = int'(ifc.Fhoog) + int'(ifc.Flaag) + int'(ifc.Alaag);
            mon_kind = 0;
            if (ifc.Fhoog)                  mon_kind = K_HOOG;
            else if (ifc.Flaag)             mon_kind = K_LAAG;
            else if (ifc.Alaag)             mon_kind = K_ALAAG;
            else if (ifc.done && !done_prev) mon_kind = K_DONE;
            if (mon_kind != 0) begin
                if (mon_kind != K_DONE) check("step_onehot", mon_hot, 1);
                if (q.size() == 0) begin
                    check("unexpected_event", mon_kind, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("event_kind", mon_kind, mon_e.kind);
                    if (mon_kind != K_DONE) check("event_f_level", int'(ifc.f_level), mon_e.lvl);
                end
            end
        end
        done_prev = ifc.done;
    end

    initial begin
        int n;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        ifc.cry   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    int'(ifc.busy), 0);
        check("rst_done",    int'(ifc.done), 0);
        check("rst_steps",   int'(ifc.Fhoog) + int'(ifc.Flaag) + int'(ifc.Alaag), 0);
        check("rst_f_level", int'(ifc.f_level), 5);
        reset = 1'b1;

        // Calm run: Flaag x5 down to F=0, then Alaag x5, then DONE
        for (int l = 4; l >= 0; l--) expect_ev(K_LAAG, l);
        for (int i = 0; i < 5; i++)  expect_ev(K_ALAAG, 0);
        expect_ev(K_DONE, 0);
        pulse_start();
        drain("calm_drain", 200);
        @(negedge clk);
        check("calm_done", int'(ifc.done), 1);
        check("calm_busy", int'(ifc.busy), 0);

        // Cry while in DONE
        @(posedge clk); #1 ifc.cry = 1'b1;
`ifdef ROCK_CRY_RESTART_EN
        expect_ev(K_HOOG, 1);
        n = 0;
        while (!ifc.busy && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("done_cry_busy", int'(ifc.busy), 1);
        drain("done_cry_drain", 40);
`else
        repeat (20) @(negedge clk);
        check("done_cry_ignored", int'(ifc.done), 1);
        check("done_cry_busy",    int'(ifc.busy), 0);
`endif
        ifc.cry = 1'b0;
        do_stop();
        check("stop_done_idle", int'(ifc.done), 0);
        check("stop_idle_busy", int'(ifc.busy), 0);

        // Async reset mid-SETTLE, between clock edges
        pulse_start();
        @(negedge clk);
        check("settle_busy", int'(ifc.busy), 1);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("areset_busy",  int'(ifc.busy), 0);
        check("areset_steps", int'(ifc.Fhoog) + int'(ifc.Flaag) + int'(ifc.Alaag), 0);
        check("areset_f",     int'(ifc.f_level), 5);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("release_f_level", int'(ifc.f_level), 5);

        // Brief cry: one synced cry cycle mid-window -> Fhoog, then Flaag
        expect_ev(K_HOOG, 6);
        expect_ev(K_LAAG, 5);
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0; ifc.cry = 1'b1;
        @(posedge clk); #1 ifc.cry = 1'b0;
        drain("brief_drain", 60);
        do_stop();
        check("brief_stop_busy", int'(ifc.busy), 0);

        // Cry escalation: two Fhoog to F_MAX, then quiet windows
        @(posedge clk); #1 ifc.cry = 1'b1;
        repeat (3) @(posedge clk);
        expect_ev(K_HOOG, 6);
        expect_ev(K_HOOG, 7);
        pulse_start();
        drain("esc_drain", 60);
        repeat (30) @(negedge clk);
        check("esc_f_level", int'(ifc.f_level), 7);
        check("esc_busy",    int'(ifc.busy), 1);

        // stop during PULSE
        #1 ifc.cry = 1'b0;
        expect_ev(K_LAAG, 6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.Flaag && n < 40);
        check("pulse_seen", int'(ifc.Flaag), 1);
        ifc.stop = 1'b1;
        @(negedge clk);
        check("stop_pulse_low", int'(ifc.Flaag), 0);
        check("stop_busy",      int'(ifc.busy), 0);
        check("stop_f_level",   int'(ifc.f_level), 6);
        ifc.stop = 1'b0;
        repeat (10) @(negedge clk);
        check("final_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
